// File: rtl/exec_alu_pkg.sv
// Shared codes for the execute-stage ALU: op classes, internal op encoding, FSM states and
// func7 patterns, plus small decode helpers.
package exec_alu_pkg;

  localparam logic [2:0] LoadStoreType  = 3'd0;
  localparam logic [2:0] JTypeALU       = 3'd1;
  localparam logic [2:0] ITypeJALR_ALU  = 3'd2;
  localparam logic [2:0] UTypeALU       = 3'd3;
  localparam logic [2:0] UTypeAUIPC_ALU = 3'd4;
  localparam logic [2:0] BTypeALU       = 3'd5;
  localparam logic [2:0] RTypeALU       = 3'd6;
  localparam logic [2:0] ITypeALU       = 3'd7;

  typedef enum logic [4:0] {
    OpAdd    = 5'd0,
    OpSub    = 5'd1,
    OpSll    = 5'd2,
    OpSlt    = 5'd3,
    OpSltu   = 5'd4,
    OpXor    = 5'd5,
    OpSrl    = 5'd6,
    OpSra    = 5'd7,
    OpOr     = 5'd8,
    OpAnd    = 5'd9,
    OpBeq    = 5'd10,
    OpBne    = 5'd11,
    OpBlt    = 5'd12,
    OpBge    = 5'd13,
    OpBltu   = 5'd14,
    OpBgeu   = 5'd15,
    OpMul    = 5'd16,
    OpMulh   = 5'd17,
    OpMulhsu = 5'd18,
    OpMulhu  = 5'd19,
    OpDiv    = 5'd20,
    OpDivu   = 5'd21,
    OpRem    = 5'd22,
    OpRemu   = 5'd23,
    OpNone   = 5'd24
  } alu_op_e;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam logic [6:0] FUNC7_ALT    = 7'b0100000;
  localparam logic [6:0] FUNC7_MULDIV = 7'b0000001;

  // Register/immediate integer ops shared by R and I classes.
  function automatic alu_op_e base_op(input logic [2:0] f3, input logic arith_shift);
    alu_op_e op;
    case (f3)
      3'b000:  op = OpAdd;
      3'b001:  op = OpSll;
      3'b010:  op = OpSlt;
      3'b011:  op = OpSltu;
      3'b100:  op = OpXor;
      3'b101:  op = arith_shift ? OpSra : OpSrl;
      3'b110:  op = OpOr;
      default: op = OpAnd;
    endcase
    return op;
  endfunction

  function automatic logic is_mul(input alu_op_e op);
    return op[4:2] == 3'b100;
  endfunction

  function automatic logic is_div(input alu_op_e op);
    return op[4:2] == 3'b101;
  endfunction

  function automatic logic op_a_signed(input alu_op_e op);
    return op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
  endfunction

  function automatic logic op_b_signed(input alu_op_e op);
    return op inside {OpMulh, OpDiv, OpRem};
  endfunction

endpackage

// File: rtl/exec_alu_muldiv_iter.sv
// Radix-2 iterative engine on operand magnitudes: shift-add multiply or restoring divide.
// Exposes the next-step values so the final step and sign fixup can share one clock edge.
module exec_alu_muldiv_iter
  import exec_alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            start,
  input  logic            step,
  input  logic            is_div,
  input  logic [XLEN-1:0] a_mag,
  input  logic [XLEN-1:0] b_mag,
  output logic            last,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN-1:0]  hi_q, lo_q, opnd_q;
  logic             div_q;
  logic [CNT_W-1:0] cnt_q;

  logic [XLEN:0] sum, shifted, diff;

  // Multiply: {hi,lo} holds partial product / multiplier. Divide: hi = remainder, lo = quotient.
  always_comb begin
    sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    shifted = {hi_q, lo_q[XLEN-1]};
    diff    = shifted - {1'b0, opnd_q};
    if (div_q) begin
      if (!diff[XLEN]) begin
        hi_nxt = diff[XLEN-1:0];
        lo_nxt = {lo_q[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = shifted[XLEN-1:0];
        lo_nxt = {lo_q[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_nxt = sum[XLEN:1];
      lo_nxt = {sum[0], lo_q[XLEN-1:1]};
    end
  end

  assign last = (cnt_q == CNT_W'(XLEN - 1));

  always_ff @(posedge clk) begin
    if (!rstN) begin
      hi_q   <= '0;
      lo_q   <= '0;
      opnd_q <= '0;
      div_q  <= 1'b0;
      cnt_q  <= '0;
    end else if (start) begin
      hi_q   <= '0;
      lo_q   <= a_mag;
      opnd_q <= b_mag;
      div_q  <= is_div;
      cnt_q  <= '0;
    end else if (step) begin
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/exec_alu_muldiv.sv
// Registered execute-stage ALU with RV-M multiply/divide behind a valid/ready handshake.
// Build option FAST_MUL_EN: multiplies complete in one cycle on a full-width multiplier.
module exec_alu_muldiv
  import exec_alu_pkg::*;
#(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
  input  logic            clk,
  input  logic            rstN,
  input  logic            flush,
  input  logic            inValid,
  output logic            inReady,
  input  logic [2:0]      aluClass,
  input  logic [2:0]      func3,
  input  logic [6:0]      func7,
  input  logic [XLEN-1:0] operandA,
  input  logic [XLEN-1:0] operandB,
  output logic            outValid,
  input  logic            outReady,
  output logic [XLEN-1:0] result,
  output logic            branchTaken,
  output logic            busy
);

  localparam int unsigned ShW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  alu_op_e op;
  always_comb begin
    op = OpNone;
    case (aluClass)
      LoadStoreType, JTypeALU, ITypeJALR_ALU, UTypeALU, UTypeAUIPC_ALU: op = OpAdd;
      BTypeALU: begin
        case (func3)
          3'b000:  op = OpBeq;
          3'b001:  op = OpBne;
          3'b100:  op = OpBlt;
          3'b101:  op = OpBge;
          3'b110:  op = OpBltu;
          3'b111:  op = OpBgeu;
          default: op = OpNone;
        endcase
      end
      RTypeALU: begin
        if (func7 == FUNC7_ALT) begin
          op = (func3 == 3'b000) ? OpSub : (func3 == 3'b101) ? OpSra : OpNone;
        end else if (func7 == FUNC7_MULDIV) begin
          op = alu_op_e'({2'b10, func3});
        end else begin
          op = base_op(func3, 1'b0);
        end
      end
      default: op = base_op(func3, func7[5]);
    endcase
  end

  logic            a_neg, b_neg, div_zero, div_ovf, use_iter, accept;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [ShW-1:0]  shamt;
  logic            eq, lt, ltu;

  assign a_neg    = op_a_signed(op) & operandA[XLEN-1];
  assign b_neg    = op_b_signed(op) & operandB[XLEN-1];
  assign a_mag    = a_neg ? -operandA : operandA;
  assign b_mag    = b_neg ? -operandB : operandB;
  assign div_zero = (operandB == '0);
  assign div_ovf  = (op == OpDiv || op == OpRem) && operandA == MinVal && operandB == '1;
  assign shamt    = operandB[ShW-1:0];
  assign eq       = (operandA == operandB);
  assign lt       = ($signed(operandA) < $signed(operandB));
  assign ltu      = (operandA < operandB);

`ifdef FAST_MUL_EN
  logic [2*XLEN-1:0] mag_prod, fast_prod;
  assign mag_prod  = {{XLEN{1'b0}}, a_mag} * {{XLEN{1'b0}}, b_mag};
  assign fast_prod = (a_neg ^ b_neg) ? -mag_prod : mag_prod;
  assign use_iter  = is_div(op) && !div_zero && !div_ovf;
`else
  assign use_iter  = is_mul(op) || (is_div(op) && !div_zero && !div_ovf);
`endif

  logic [XLEN-1:0] alu_res;
  logic            alu_br;
  // Divide entries only cover the special cases; ordinary divides go to the engine.
  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    case (op)
      OpAdd:          alu_res = operandA + operandB;
      OpSub:          alu_res = operandA - operandB;
      OpSll:          alu_res = operandA << shamt;
      OpSrl:          alu_res = operandA >> shamt;
      OpSra:          alu_res = $unsigned($signed(operandA) >>> shamt);
      OpSlt:          alu_res[0] = lt;
      OpSltu:         alu_res[0] = ltu;
      OpXor:          alu_res = operandA ^ operandB;
      OpOr:           alu_res = operandA | operandB;
      OpAnd:          alu_res = operandA & operandB;
      OpBeq:          alu_br = eq;
      OpBne:          alu_br = !eq;
      OpBlt:          alu_br = lt;
      OpBge:          alu_br = !lt;
      OpBltu:         alu_br = ltu;
      OpBgeu:         alu_br = !ltu;
      OpDiv, OpDivu:  alu_res = div_zero ? '1 : MinVal;
      OpRem, OpRemu:  alu_res = div_zero ? operandA : '0;
`ifdef FAST_MUL_EN
      OpMul:          alu_res = fast_prod[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: alu_res = fast_prod[2*XLEN-1:XLEN];
`endif
      default: ;
    endcase
    alu_res[0] = alu_res[0] | alu_br;
  end

  logic [1:0]      state_q, state_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            branch_q, branch_d;
  alu_op_e         op_q, op_d;
  logic            neg_q, neg_d, rneg_q, rneg_d;
  logic            start, step, iter_last;
  logic [XLEN-1:0] hi_nxt, lo_nxt, iter_res;
  logic [2*XLEN-1:0] prod_fix;

  exec_alu_muldiv_iter #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk    (clk),
    .rstN   (rstN),
    .start  (start),
    .step   (step),
    .is_div (is_div(op)),
    .a_mag  (a_mag),
    .b_mag  (b_mag),
    .last   (iter_last),
    .hi_nxt (hi_nxt),
    .lo_nxt (lo_nxt)
  );

  // neg_q negates product/quotient; rneg_q gives the remainder the dividend's sign.
  always_comb begin
    prod_fix = neg_q ? -{hi_nxt, lo_nxt} : {hi_nxt, lo_nxt};
    case (op_q)
      OpMul:                     iter_res = prod_fix[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: iter_res = prod_fix[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             iter_res = neg_q ? -lo_nxt : lo_nxt;
      OpRem, OpRemu:             iter_res = rneg_q ? -hi_nxt : hi_nxt;
      default:                   iter_res = '0;
    endcase
  end

  assign inReady = (state_q == StIdle) || (state_q == StDone && outReady);
  assign accept  = inValid && inReady;
  assign step    = (state_q == StBusy) && !flush;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    branch_d = branch_q;
    op_d     = op_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    start    = 1'b0;
    if (flush) begin
      state_d = StIdle;
    end else begin
      case (state_q)
        StBusy: begin
          if (iter_last) begin
            state_d  = StDone;
            result_d = iter_res;
            branch_d = 1'b0;
          end
        end
        StIdle, StDone: begin
          if (state_q == StDone && outReady) state_d = StIdle;
          if (accept) begin
            if (use_iter) begin
              state_d = StBusy;
              start   = 1'b1;
              op_d    = op;
              neg_d   = a_neg ^ b_neg;
              rneg_d  = a_neg;
            end else begin
              state_d  = StDone;
              result_d = alu_res;
              branch_d = alu_br;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q  <= StIdle;
      result_q <= '0;
      branch_q <= 1'b0;
      op_q     <= OpAdd;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      branch_q <= branch_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
    end
  end

  assign outValid    = (state_q == StDone);
  assign busy        = (state_q == StBusy);
  assign result      = result_q;
  assign branchTaken = branch_q;

endmodule

// File: tb/tb_exec_alu_muldiv.sv
// Bench for exec_alu_muldiv: directed literal cases plus random traffic against a
// cycle-level behavioural model built from 64-bit arithmetic.
module tb_exec_alu_muldiv;

  localparam int unsigned XLEN = 32;

  logic        clk = 1'b0;
  logic        rstN = 1'b0;
  logic        flush = 1'b0;
  logic        inValid = 1'b0;
  logic        outReady = 1'b1;
  logic [2:0]  aluClass = '0;
  logic [2:0]  func3 = '0;
  logic [6:0]  func7 = '0;
  logic [31:0] operandA = '0;
  logic [31:0] operandB = '0;
  logic        inReady, outValid, branchTaken, busy;
  logic [31:0] result;

  int checks = 0;
  int errors = 0;

  exec_alu_muldiv #(.XLEN(XLEN)) dut (
    .clk         (clk),
    .rstN        (rstN),
    .flush       (flush),
    .inValid     (inValid),
    .inReady     (inReady),
    .aluClass    (aluClass),
    .func3       (func3),
    .func7       (func7),
    .operandA    (operandA),
    .operandB    (operandB),
    .outValid    (outValid),
    .outReady    (outReady),
    .result      (result),
    .branchTaken (branchTaken),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected result from the instruction semantics; it = result needs the multi-cycle engine.
  function automatic void ref_op(input logic [2:0] cls, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [31:0] a,
                                 input logic [31:0] b, output logic [31:0] res,
                                 output logic br, output logic it);
    longint sa, sb, ps;
    longint unsigned ua, ub, pu;
    sa = $signed(a);
    sb = $signed(b);
    ua = a;
    ub = b;
    res = '0;
    br = 1'b0;
    it = 1'b0;
    if (cls <= 3'd4) begin
      res = a + b;
    end else if (cls == 3'd5) begin
      case (f3)
        3'd0: br = (a == b);
        3'd1: br = (a != b);
        3'd4: br = (sa < sb);
        3'd5: br = (sa >= sb);
        3'd6: br = (ua < ub);
        3'd7: br = (ua >= ub);
        default: br = 1'b0;
      endcase
      res = {31'd0, br};
    end else if (cls == 3'd6 && f7 == 7'h01) begin
`ifdef FAST_MUL_EN
      it = 1'b0;
`else
      it = (f3 < 3'd4);
`endif
      case (f3)
        3'd0: begin pu = ua * ub; res = pu[31:0]; end
        3'd1: begin ps = sa * sb; res = ps[63:32]; end
        3'd2: begin ps = sa * longint'(ub); res = ps[63:32]; end
        3'd3: begin pu = ua * ub; res = pu[63:32]; end
        3'd4: begin
          if (b == 0) res = '1;
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = a;
          else begin ps = sa / sb; res = ps[31:0]; it = 1'b1; end
        end
        3'd5: begin
          if (b == 0) res = '1;
          else begin pu = ua / ub; res = pu[31:0]; it = 1'b1; end
        end
        3'd6: begin
          if (b == 0) res = a;
          else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = '0;
          else begin ps = sa % sb; res = ps[31:0]; it = 1'b1; end
        end
        default: begin
          if (b == 0) res = a;
          else begin pu = ua % ub; res = pu[31:0]; it = 1'b1; end
        end
      endcase
    end else if (cls == 3'd6 && f7 == 7'h20) begin
      if (f3 == 3'd0) res = a - b;
      else if (f3 == 3'd5) begin ps = sa >>> b[4:0]; res = ps[31:0]; end
      else res = '0;
    end else begin
      case (f3)
        3'd0: res = a + b;
        3'd1: res = a << b[4:0];
        3'd2: res = (sa < sb) ? 32'd1 : 32'd0;
        3'd3: res = (ua < ub) ? 32'd1 : 32'd0;
        3'd4: res = a ^ b;
        3'd5: begin
          if (cls == 3'd7 && f7[5]) begin ps = sa >>> b[4:0]; res = ps[31:0]; end
          else res = a >> b[4:0];
        end
        3'd6: res = a | b;
        default: res = a & b;
      endcase
    end
  endfunction

  // Model: m_busy counts remaining engine cycles; m_known marks a defined expected result.
  bit          m_init = 0, m_valid = 0, m_br = 0, m_known = 0, p_it, p_br, exp_ready;
  int          m_busy = 0;
  logic [31:0] m_res = '0, p_res = '0, r_res;

  always @(negedge clk) begin
    exp_ready = (m_busy == 0) && (!m_valid || outReady);
    if (m_init) begin
      chk("outValid", outValid, 32'(m_valid));
      chk("busy", busy, 32'(m_busy > 0));
      chk("inReady", inReady, 32'(exp_ready));
      if (m_known) begin
        chk("result", result, m_res);
        chk("branchTaken", branchTaken, 32'(m_br));
      end
    end
    if (!rstN) begin
      m_init = 1; m_valid = 0; m_busy = 0; m_res = '0; m_br = 0; m_known = 1;
    end else if (m_init) begin
      if (flush) begin
        m_valid = 0; m_busy = 0; m_known = 0;
      end else if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_valid = 1; m_res = p_res; m_br = 0; m_known = 1;
        end
      end else begin
        if (m_valid && outReady) begin m_valid = 0; m_known = 0; end
        if (inValid && exp_ready) begin
          ref_op(aluClass, func3, func7, operandA, operandB, r_res, p_br, p_it);
          m_known = 0;
          if (p_it) begin
            m_busy = XLEN; p_res = r_res;
          end else begin
            m_valid = 1; m_res = r_res; m_br = p_br; m_known = 1;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] c, input logic [2:0] f3, input logic [6:0] f7,
                       input logic [31:0] a, input logic [31:0] b);
    aluClass = c; func3 = f3; func7 = f7; operandA = a; operandB = b;
  endtask

  task automatic send(input logic [2:0] c, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] a, input logic [31:0] b);
    bit ok = 0;
    drive(c, f3, f7, a, b);
    inValid = 1'b1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (inReady) begin ok = 1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: actual inReady 0 required 1 (t=%0t)", $time);
    end
    step();
    inValid = 1'b0;
  endtask

  task automatic wait_valid(output int n, output int nbusy);
    n = 0; nbusy = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (busy) nbusy++;
      if (outValid) break;
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return $urandom_range(0, 15);
      default: return $urandom;
    endcase
  endfunction

  int lat, nb;
`ifdef FAST_MUL_EN
  localparam int MulLat = 1;
  localparam int MulBusy = 0;
`else
  localparam int MulLat = 33;
  localparam int MulBusy = 32;
`endif

  initial begin
    repeat (2) @(posedge clk);
    #1 rstN = 1'b1;
    @(negedge clk);
    chk("rst_outValid", outValid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_result", result, 0);
    chk("rst_inReady", inReady, 1);
    step();

    // ADD then back-to-back SUB accepted while ADD result is presented
    send(3'd6, 3'd0, 7'h00, 32'd7, 32'd5);
    drive(3'd6, 3'd0, 7'h20, 32'd5, 32'd7);
    inValid = 1'b1;
    @(negedge clk);
    chk("add_valid", outValid, 1);
    chk("add_result", result, 32'd12);
    chk("b2b_inReady", inReady, 1);
    step();
    inValid = 1'b0;
    @(negedge clk);
    chk("sub_result", result, 32'hFFFF_FFFE);
    step();

    send(3'd5, 3'd4, 7'h00, 32'hFFFF_FFFF, 32'd1);
    wait_valid(lat, nb);
    chk("blt_lat", lat, 1);
    chk("blt_taken", branchTaken, 1);
    chk("blt_result", result, 1);
    step();
    send(3'd5, 3'd6, 7'h00, 32'hFFFF_FFFF, 32'd1);
    wait_valid(lat, nb);
    chk("bltu_taken", branchTaken, 0);
    chk("bltu_result", result, 0);
    step();

    send(3'd6, 3'd1, 7'h01, 32'h8000_0000, 32'h8000_0000);
    wait_valid(lat, nb);
    chk("mulh_busy_cycles", nb, MulBusy);
    chk("mulh_lat", lat, MulLat);
    chk("mulh_result", result, 32'h4000_0000);
    step();

    send(3'd6, 3'd4, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_valid(lat, nb);
    chk("div_ovf_lat", lat, 1);
    chk("div_ovf_result", result, 32'h8000_0000);
    step();
    send(3'd6, 3'd7, 7'h01, 32'd9, 32'd0);
    wait_valid(lat, nb);
    chk("remu_zero_lat", lat, 1);
    chk("remu_zero_result", result, 32'd9);
    step();

    send(3'd6, 3'd4, 7'h01, 32'hFFFF_FFF9, 32'd2);
    wait_valid(lat, nb);
    chk("div_lat", lat, 33);
    chk("div_result", result, 32'hFFFF_FFFD);
    step();
    outReady = 1'b0;
    send(3'd6, 3'd6, 7'h01, 32'hFFFF_FFF9, 32'd2);
    wait_valid(lat, nb);
    chk("rem_result", result, 32'hFFFF_FFFF);
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge clk);
      chk("hold_result", result, 32'hFFFF_FFFF);
      chk("hold_valid", outValid, 1);
      chk("hold_inReady", inReady, 0);
    end
    step();
    outReady = 1'b1;
    step();

    // Flush in busy cycle 10 of a DIVU, then ADD straight after
    send(3'd6, 3'd5, 7'h01, 32'd100, 32'd7);
    repeat (9) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    drive(3'd0, 3'd0, 7'h00, 32'd3, 32'd4);
    inValid = 1'b1;
    @(negedge clk);
    chk("flush_idle_ready", inReady, 1);
    chk("flush_no_valid", outValid, 0);
    chk("flush_not_busy", busy, 0);
    step();
    inValid = 1'b0;
    @(negedge clk);
    chk("post_flush_add", result, 32'd7);
    step();

    // Reset during busy abandons the divide
    send(3'd6, 3'd4, 7'h01, 32'd100, 32'd7);
    repeat (5) step();
    rstN = 1'b0;
    step();
    rstN = 1'b1;
    @(negedge clk);
    chk("rstbusy_outValid", outValid, 0);
    chk("rstbusy_busy", busy, 0);
    chk("rstbusy_result", result, 0);
    chk("rstbusy_branch", branchTaken, 0);
    step();

    for (int i = 0; i < 4000; i++) begin
      aluClass = ($urandom_range(0, 2) == 0) ? 3'd6 : 3'($urandom_range(0, 7));
      func3 = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: func7 = 7'h00;
        1: func7 = 7'h20;
        2: func7 = 7'h01;
        default: func7 = 7'($urandom);
      endcase
      operandA = pick();
      operandB = pick();
      inValid = ($urandom_range(0, 3) != 0);
      outReady = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 49) == 0);
      step();
    end
    inValid = 1'b0;
    flush = 1'b0;
    outReady = 1'b1;
    repeat (40) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/exec_alu_muldiv.md
Name: exec_alu_muldiv

Overview:
- Registered execute-stage ALU for the pipelined RISC-V core; parametrised successor to the combinational ALU-control decoder.
- Decodes op class + func3/func7, computes integer, branch and RV-M multiply/divide results, and delivers them through a valid/ready handshake.
- Single-cycle ops return in one cycle. MUL/DIV run on an iterative radix-2 engine and stall the pipeline through inReady.

Parameters:
- XLEN, 32, datapath width (32 or 64); shift amount uses the low $clog2(XLEN) bits of operandB.
- CNT_W, $clog2(XLEN)+1, width of the iteration counter.

Ports:
- clk  in  1  core clock
- rstN  in  1  synchronous active-low reset
- flush  in  1  kill in-flight op (branch mispredict/trap)
- inValid  in  1  operands and op valid
- inReady  out  1  unit can accept this cycle
- aluClass  in  3  op class, package codes
- func3  in  3  instruction func3
- func7  in  7  instruction func7
- operandA  in  XLEN  rs1/PC operand
- operandB  in  XLEN  rs2/imm operand
- outValid  out  1  result valid
- outReady  in  1  downstream accepts result
- result  out  XLEN  ALU/MUL/DIV result
- branchTaken  out  1  branch condition result (B class only)
- busy  out  1  iterative engine active

Behaviour:
- Reset (rstN=0 at a clk edge): state=IDLE; outValid, branchTaken, busy = 0; result = 0; counter = 0. Reset mid-iteration abandons the op.
- Decode classes:
  - LoadStore/J/JALR/U/AUIPC: ADD.
  - B: func3 000/001/100/101/110/111 = EQ/NE/LT/GE/LTU/GEU. branchTaken = condition; result = {0..,cond}.
  - R with func7=0100000: SUB (f3=000) or SRA (f3=101).
  - R with func7=0000001: M-ext. f3 000..111 = MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - Other R: ADD/AND/OR/XOR/SLL/SRL/SLT/SLTU.
  - I class: same ops as R; SRAI is selected by func7[5]; func7=0000001 in I class is not M-ext.
  - Undefined func3/class combinations: result=0, branchTaken=0, handshake completes normally (no X propagation).
- Handshake:
  - Accept occurs when inValid && inReady.
  - inReady = (state==IDLE) || (state==DONE && outReady).
  - outValid, result and branchTaken hold stable until outReady.
- FSM:
  - IDLE: on accept of a single-cycle op -> DONE, result registered, outValid=1 next cycle (latency 1). On accept of MUL*/DIV*/REM* -> BUSY, counter=0, operands latched; for signed ops, magnitudes latched with sign flags.
  - BUSY: one shift-add (mul) or restoring shift-subtract (div) step per cycle. After XLEN steps, sign fixup and select high/low/quotient/remainder -> DONE. Accept-to-outValid = XLEN+1 cycles.
  - DONE: if outReady && inValid, accept the next op (same transitions as IDLE). If outReady && !inValid -> IDLE. If !outReady, stay.
- Divide special cases skip BUSY, so outValid comes 1 cycle after accept:
  - divisor=0: DIV/DIVU = all ones; REM/REMU = dividend.
  - Signed overflow (MIN / -1): DIV = MIN; REM = 0.
- Flush:
  - Next state = IDLE, outValid=0, busy=0; any concurrent accept is discarded.
  - flush has priority over accept and completion in the same cycle.
- busy = (state==BUSY).
- Arithmetic:
  - All ops are modulo 2^XLEN.
  - MULH* uses the upper XLEN bits of the 2*XLEN product; MULHSU treats A signed, B unsigned.

Optional Feature:
- FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU use a single-cycle 2*XLEN multiplier and go IDLE->DONE with latency 1. Divide is unchanged.
- Undefined: all multiplies take the iterative path with latency XLEN+1.

Decomposition:
- Package exec_alu_pkg holds:
  - Class codes: LoadStoreType=0, JTypeALU=1, ITypeJALR_ALU=2, UTypeALU=3, UTypeAUIPC_ALU=4, BTypeALU=5, RTypeALU=6, ITypeALU=7.
  - 5-bit internal op enum (existing 4-bit codes plus MUL..REMU at 16..23).
  - FSM state enum IDLE/BUSY/DONE.
  - FUNC7_ALT=0100000 and FUNC7_MULDIV=0000001.
- One sub-module, exec_alu_muldiv_iter: the iterative engine with start/done, latched operands and counter. Decode, single-cycle ALU and FSM stay in the top.

Test Plan:
- R ADD A=7, B=5, outReady=1 -> outValid next cycle, result=12. Back-to-back SUB 5-7 accepted that same cycle -> result=0xFFFFFFFE the following cycle.
- B class f3=100 (BLT), A=-1, B=1 -> branchTaken=1, result=1. f3=110 (BLTU) with the same operands -> branchTaken=0.
- MULH A=0x80000000, B=0x80000000 -> inReady=0 and busy=1 for 32 cycles; result=0x40000000 at cycle 33. With FAST_MUL_EN, result is ready at cycle 1.
- DIV A=0x80000000, B=0xFFFFFFFF -> result=0x80000000 at cycle 1. REMU with B=0, A=9 -> result=9 at cycle 1.
- DIV A=-7, B=2 -> result=-3 at cycle 33. REM same operands -> result=-1. Hold outReady=0 for 5 cycles -> result stable, inReady=0.
- Assert flush at BUSY cycle 10 of a DIVU -> IDLE next cycle, outValid never asserts, new ADD accepted the cycle after. rstN=0 mid-BUSY -> all outputs 0.
